hyperbus_burst_fifo: RTL and testbench

// Single-clock, parametrised burst bridge between user command/data streams and the Hyperbus native

---
 rtl/hyperbus_burst_fifo.sv | 246 ++++++++++++++++++++++++
 tb/tb_hyperbus_burst_fifo.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_fifo.sv
// hyperbus_burst_fifo
// Burst bridge between user command / write-data / read-data streams and the
// Hyperbus native interface. Commands and write words are queued; a burst is
// launched only when it can run to completion without stalling or overflowing.
// Each user word travels as RATIO bus beats, most significant slice first.

module hyperbus_burst_fifo #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int CMD_DEPTH_LOG2  = 2,
  parameter int DATA_DEPTH_LOG2 = 4,
  parameter int MAX_BURST_LOG2  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
  input  logic [MAX_BURST_LOG2-1:0]  cmd_len,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] tx_dat,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [FIFO_DATA_WIDTH-1:0] rx_dat,
  output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  output logic                       hbus_rrq,
  output logic                       hbus_wrq,
  input  logic                       hbus_ready,
  input  logic                       hbus_valid,
  input  logic                       hbus_busy
);

  localparam int RATIO      = FIFO_DATA_WIDTH / HBUS_DATA_WIDTH;
  localparam int CNT_W      = MAX_BURST_LOG2 + $clog2(RATIO) + 1;
  localparam int SLICE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CMD_DEPTH  = 2 ** CMD_DEPTH_LOG2;
  localparam int DATA_DEPTH = 2 ** DATA_DEPTH_LOG2;
  localparam int CMD_W      = 1 + HBUS_ADDR_WIDTH + MAX_BURST_LOG2;
  localparam int CLVL_W     = CMD_DEPTH_LOG2 + 1;
  localparam int LVL_W      = DATA_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state;

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0]          cmd_mem [CMD_DEPTH];
  logic [CMD_DEPTH_LOG2-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CLVL_W-1:0]         cmd_level;
  logic                      cmd_push, cmd_pop, cmd_full;
  logic [CMD_W-1:0]          cmd_head;
  logic                      head_write;
  logic [HBUS_ADDR_WIDTH-1:0] head_adr;
  logic [MAX_BURST_LOG2-1:0] head_len;

  assign cmd_full   = (cmd_level == CLVL_W'(CMD_DEPTH));
  assign cmd_ready  = rst_n & ~cmd_full;
  assign cmd_push   = cmd_valid & cmd_ready;
  assign cmd_head   = cmd_mem[cmd_rd_ptr];
  assign head_write = cmd_head[CMD_W-1];
  assign head_adr   = cmd_head[MAX_BURST_LOG2 +: HBUS_ADDR_WIDTH];
  assign head_len   = cmd_head[MAX_BURST_LOG2-1:0];

  // Command storage: written on every accepted command, never reset.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_write, cmd_adr, cmd_len};
  end

  // Command FIFO pointers and occupancy; push and pop in one cycle cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_level  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_level <= cmd_level + 1'b1;
        2'b01:   cmd_level <= cmd_level - 1'b1;
        default: cmd_level <= cmd_level;
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  logic [FIFO_DATA_WIDTH-1:0] tx_mem [DATA_DEPTH];
  logic [DATA_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr, tx_rd_next;
  logic [LVL_W-1:0]           tx_level;
  logic                       tx_push, tx_pop;
  logic [FIFO_DATA_WIDTH-1:0] tx_head, tx_second;

  assign tx_ready   = rst_n & (tx_level != LVL_W'(DATA_DEPTH));
  assign tx_push    = tx_valid & tx_ready;
  assign tx_rd_next = tx_rd_ptr + 1'b1;
  assign tx_head    = tx_mem[tx_rd_ptr];
  assign tx_second  = tx_mem[tx_rd_next];

  // Write-word storage.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_dat;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_next;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: tx_level <= tx_level;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [FIFO_DATA_WIDTH-1:0] rx_mem [DATA_DEPTH];
  logic [DATA_DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [LVL_W-1:0]           rx_level, rx_free;
  logic                       rx_push, rx_pop;
  logic [FIFO_DATA_WIDTH-1:0] rx_shift, rx_next;

  assign rx_valid = rst_n & (rx_level != '0);
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_dat   = rx_mem[rx_rd_ptr];
  assign rx_free  = LVL_W'(DATA_DEPTH) - rx_level;
  assign rx_next  = FIFO_DATA_WIDTH'({rx_shift, hbus_dat_i});

  // Read-word storage; the assembled word goes in on its final beat.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_next;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: rx_level <= rx_level;
      endcase
    end
  end

  // ---------------- burst engine ----------------
  logic [CNT_W-1:0]           beat_cnt;
  logic [SLICE_W-1:0]         slice_cnt;
  logic [FIFO_DATA_WIDTH-1:0] tx_shift;
  logic [LVL_W-1:0]           burst_words;
  logic                       launch, wr_beat, rd_beat, word_done, last_beat;

  assign burst_words = LVL_W'(head_len) + 1'b1;
  assign launch      = (state == IDLE) && (cmd_level != '0) && !hbus_busy &&
                       (head_write ? (tx_level >= burst_words) : (rx_free >= burst_words));
  assign cmd_pop     = launch;
  assign wr_beat     = (state == WRITE) && hbus_wrq && hbus_ready;
  assign rd_beat     = (state == READ) && hbus_rrq && hbus_valid;
  assign word_done   = (slice_cnt == SLICE_W'(RATIO - 1));
  assign last_beat   = (beat_cnt == CNT_W'(1));
  assign tx_pop      = wr_beat && word_done;
  assign rx_push     = rd_beat && word_done;
  assign hbus_dat_o  = tx_shift[FIFO_DATA_WIDTH-1 -: HBUS_DATA_WIDTH];

  // Burst FSM: launches only fully-buffered writes or space-reserved reads,
  // then counts beats down and drops the request after the final beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hbus_wrq   <= 1'b0;
      hbus_rrq   <= 1'b0;
      hbus_adr_o <= '0;
      beat_cnt   <= '0;
      slice_cnt  <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            hbus_adr_o <= head_adr;
            beat_cnt   <= (CNT_W'(head_len) + 1'b1) * CNT_W'(RATIO);
            slice_cnt  <= '0;
            if (head_write) begin
              state    <= WRITE;
              hbus_wrq <= 1'b1;
              tx_shift <= tx_head;
            end else begin
              state    <= READ;
              hbus_rrq <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_beat) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (word_done) begin
              slice_cnt <= '0;
              tx_shift  <= tx_second;
            end else begin
              slice_cnt <= slice_cnt + 1'b1;
              tx_shift  <= tx_shift << HBUS_DATA_WIDTH;
            end
            if (last_beat) begin
              hbus_wrq <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        READ: begin
          if (rd_beat) begin
            beat_cnt <= beat_cnt - 1'b1;
            rx_shift <= rx_next;
            if (word_done) slice_cnt <= '0;
            else           slice_cnt <= slice_cnt + 1'b1;
            if (last_beat) begin
              hbus_rrq <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          hbus_wrq <= 1'b0;
          hbus_rrq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// tb_hyperbus_burst_fifo
// Directed bench: a cycle-by-cycle vector table for the basic write and read
// bursts, followed by hand-written sequences for stalls, backpressure, busy
// blocking, command ordering and mid-burst reset.

module tb_hyperbus_burst_fifo;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_len;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_dat;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_dat;
  logic [31:0] hbus_adr_o;
  logic [15:0] hbus_dat_i, hbus_dat_o;
  logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] expq [$];

  typedef struct packed {
    logic        cmd_valid;
    logic        cmd_write;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic        tx_valid;
    logic [31:0] tx_dat;
    logic        hbus_ready;
    logic        hbus_valid;
    logic [15:0] hbus_dat;
    logic        rx_ready;
    logic        exp_wrq;
    logic        exp_rrq;
    logic        chk_dat;
    logic [15:0] exp_dat;
    logic        chk_adr;
    logic [31:0] exp_adr;
    logic        chk_rx;
    logic        exp_rx_valid;
    logic [31:0] exp_rx_dat;
  } vec_t;

  vec_t vecs [$];

  hyperbus_burst_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_adr    (cmd_adr),
    .cmd_len    (cmd_len),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_dat     (tx_dat),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_dat     (rx_dat),
    .hbus_adr_o (hbus_adr_o),
    .hbus_dat_i (hbus_dat_i),
    .hbus_dat_o (hbus_dat_o),
    .hbus_rrq   (hbus_rrq),
    .hbus_wrq   (hbus_wrq),
    .hbus_ready (hbus_ready),
    .hbus_valid (hbus_valid),
    .hbus_busy  (hbus_busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence ever locks up.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyIdle();
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_adr    = '0;
    cmd_len    = '0;
    tx_valid   = 1'b0;
    tx_dat     = '0;
    hbus_ready = 1'b0;
    hbus_valid = 1'b0;
    hbus_dat_i = '0;
    rx_ready   = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    cmd_valid  = v.cmd_valid;
    cmd_write  = v.cmd_write;
    cmd_adr    = v.cmd_adr;
    cmd_len    = v.cmd_len;
    tx_valid   = v.tx_valid;
    tx_dat     = v.tx_dat;
    hbus_ready = v.hbus_ready;
    hbus_valid = v.hbus_valid;
    hbus_dat_i = v.hbus_dat;
    rx_ready   = v.rx_ready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    #1;
    checkValue($sformatf("row%0d wrq", idx), hbus_wrq, v.exp_wrq);
    checkValue($sformatf("row%0d rrq", idx), hbus_rrq, v.exp_rrq);
    if (v.chk_dat) checkValue($sformatf("row%0d dat_o", idx), hbus_dat_o, v.exp_dat);
    if (v.chk_adr) checkValue($sformatf("row%0d adr_o", idx), hbus_adr_o, v.exp_adr);
    if (v.chk_rx) begin
      checkValue($sformatf("row%0d rx_valid", idx), rx_valid, v.exp_rx_valid);
      if (v.exp_rx_valid) checkValue($sformatf("row%0d rx_dat", idx), rx_dat, v.exp_rx_dat);
    end
  endtask

  task automatic issueCmd(input logic w, input logic [31:0] adr, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_adr   = adr;
    cmd_len   = len;
    checkValue("cmd_ready on issue", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for a read burst, feeds n beats and records the words the
  // RX FIFO should receive: each pair of beats forms one word, first beat high.
  task automatic feedRead(input int n, input logic [15:0] base, input logic [31:0] adr);
    int w;
    logic [15:0] prev, cur;
    w = 0;
    prev = '0;
    while (!hbus_rrq && w < 20) begin
      tick();
      w++;
    end
    checkValue("read rrq rise", hbus_rrq, 1);
    checkValue("read adr_o", hbus_adr_o, adr);
    for (int i = 0; i < n; i++) begin
      cur = base + 16'(i);
      hbus_valid = 1'b1;
      hbus_dat_i = cur;
      if (i % 2 == 1) expq.push_back({prev, cur});
      prev = cur;
      tick();
    end
    hbus_valid = 1'b0;
    checkValue("read rrq drop", hbus_rrq, 0);
  endtask

  task automatic drainOne();
    rx_ready = 1'b1;
    checkValue("drain rx_valid", rx_valid, 1);
    checkValue("drain rx_dat", rx_dat, expq[0]);
    void'(expq.pop_front());
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic drainAll();
    int guard;
    guard = 0;
    while (expq.size() > 0 && guard < 40) begin
      drainOne();
      guard++;
    end
    checkValue("rx empty after drain", rx_valid, 0);
  endtask

  initial begin
    int seen;
    int beat;
    logic [15:0] exp_beat;

    applyIdle();
    hbus_busy = 1'b0;
    rst_n     = 1'b0;

    // ---------- reset state ----------
    tick();
    tick();
    checkValue("reset cmd_ready", cmd_ready, 0);
    checkValue("reset tx_ready", tx_ready, 0);
    checkValue("reset rx_valid", rx_valid, 0);
    checkValue("reset wrq", hbus_wrq, 0);
    checkValue("reset rrq", hbus_rrq, 0);
    checkValue("reset adr_o", hbus_adr_o, 0);
    checkValue("reset dat_o", hbus_dat_o, 0);
    rst_n = 1'b1;
    tick();
    checkValue("post-reset cmd_ready", cmd_ready, 1);
    checkValue("post-reset tx_ready", tx_ready, 1);

    // ---------- vector table: single-word write, then 4-word read ----------
    vecs.push_back(vec_t'{cmd_valid:1'b1, cmd_write:1'b1, cmd_adr:32'h100, tx_valid:1'b1,
                          tx_dat:32'hDEADBEEF, hbus_ready:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_ready:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_ready:1'b1, exp_wrq:1'b1, chk_dat:1'b1, exp_dat:16'hDEAD,
                          chk_adr:1'b1, exp_adr:32'h100, default:0});
    vecs.push_back(vec_t'{hbus_ready:1'b1, exp_wrq:1'b1, chk_dat:1'b1, exp_dat:16'hBEEF,
                          chk_adr:1'b1, exp_adr:32'h100, default:0});
    vecs.push_back(vec_t'{chk_rx:1'b1, default:0});
    vecs.push_back(vec_t'{cmd_valid:1'b1, cmd_adr:32'h40, cmd_len:4'd3, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'hFFFF, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0001, exp_rrq:1'b1,
                          chk_adr:1'b1, exp_adr:32'h40, chk_rx:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0002, exp_rrq:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0003, exp_rrq:1'b1, chk_rx:1'b1,
                          exp_rx_valid:1'b1, exp_rx_dat:32'h00010002, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0004, exp_rrq:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0005, exp_rrq:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0006, exp_rrq:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0007, exp_rrq:1'b1, default:0});
    vecs.push_back(vec_t'{hbus_valid:1'b1, hbus_dat:16'h0008, exp_rrq:1'b1, default:0});
    vecs.push_back(vec_t'{rx_ready:1'b1, chk_rx:1'b1, exp_rx_valid:1'b1, exp_rx_dat:32'h00010002, default:0});
    vecs.push_back(vec_t'{rx_ready:1'b1, chk_rx:1'b1, exp_rx_valid:1'b1, exp_rx_dat:32'h00030004, default:0});
    vecs.push_back(vec_t'{rx_ready:1'b1, chk_rx:1'b1, exp_rx_valid:1'b1, exp_rx_dat:32'h00050006, default:0});
    vecs.push_back(vec_t'{rx_ready:1'b1, chk_rx:1'b1, exp_rx_valid:1'b1, exp_rx_dat:32'h00070008, default:0});
    vecs.push_back(vec_t'{chk_rx:1'b1, default:0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end
    applyIdle();

    // ---------- partially buffered write waits for its data ----------
    $display("[TB] write burst waiting on TX data");
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 32'h200; cmd_len = 4'd3;
    tx_valid  = 1'b1; tx_dat = 32'h11112222;
    tick();
    cmd_valid = 1'b0;
    tx_dat    = 32'h33334444;
    tick();
    tx_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (hbus_wrq) seen++;
      tick();
    end
    checkValue("t3 no wrq with 2 words", seen, 0);
    tx_valid = 1'b1; tx_dat = 32'h55556666;
    tick();
    tx_dat = 32'h77778888;
    tick();
    tx_valid = 1'b0;
    checkValue("t3 wrq low while launching", hbus_wrq, 0);
    tick();
    checkValue("t3 wrq high", hbus_wrq, 1);
    checkValue("t3 adr_o", hbus_adr_o, 32'h200);
    beat = 0;
    for (int c = 0; c < 30 && beat < 8; c++) begin
      hbus_ready = (c != 2);
      if (hbus_wrq && hbus_ready) begin
        exp_beat = 16'h1111 * 16'(beat + 1);
        checkValue($sformatf("t3 beat%0d", beat), hbus_dat_o, exp_beat);
        beat++;
      end
      tick();
    end
    hbus_ready = 1'b0;
    checkValue("t3 beat count", beat, 8);
    checkValue("t3 wrq drop", hbus_wrq, 0);

    // ---------- read held off until RX space is reserved ----------
    $display("[TB] read blocked by RX space");
    issueCmd(1'b0, 32'h600, 4'd13);
    feedRead(28, 16'h0100, 32'h600);
    issueCmd(1'b0, 32'h700, 4'd3);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (hbus_rrq) seen++;
      tick();
    end
    checkValue("t4 rrq held, 2 free", seen, 0);
    drainOne();
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (hbus_rrq) seen++;
      tick();
    end
    checkValue("t4 rrq held, 3 free", seen, 0);
    drainOne();
    feedRead(8, 16'h0200, 32'h700);
    drainAll();

    // ---------- busy blocks launch; queued commands keep order ----------
    $display("[TB] busy blocking and ordering");
    hbus_busy = 1'b1;
    tx_valid  = 1'b1; tx_dat = 32'hCAFEF00D;
    issueCmd(1'b1, 32'h300, 4'd0);
    tx_valid = 1'b0;
    issueCmd(1'b0, 32'h340, 4'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (hbus_wrq || hbus_rrq) seen++;
      tick();
    end
    checkValue("t5 no launch while busy", seen, 0);
    hbus_busy = 1'b0;
    checkValue("t5 wrq low before release edge", hbus_wrq, 0);
    tick();
    checkValue("t5 wrq after release", hbus_wrq, 1);
    checkValue("t5 rrq waits for write", hbus_rrq, 0);
    checkValue("t5 write adr_o", hbus_adr_o, 32'h300);
    hbus_ready = 1'b1;
    checkValue("t5 beat0", hbus_dat_o, 16'hCAFE);
    tick();
    checkValue("t5 beat1", hbus_dat_o, 16'hF00D);
    tick();
    hbus_ready = 1'b0;
    checkValue("t5 wrq drop", hbus_wrq, 0);
    feedRead(2, 16'hA000, 32'h340);
    drainAll();

    // ---------- reset in the middle of a read burst ----------
    $display("[TB] mid-burst reset");
    issueCmd(1'b0, 32'h500, 4'd3);
    seen = 0;
    while (!hbus_rrq && seen < 20) begin
      tick();
      seen++;
    end
    checkValue("t6 rrq rise", hbus_rrq, 1);
    for (int i = 0; i < 3; i++) begin
      hbus_valid = 1'b1;
      hbus_dat_i = 16'h5000 + 16'(i);
      tick();
    end
    hbus_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checkValue("t6 rrq after reset", hbus_rrq, 0);
    checkValue("t6 rx_valid in reset", rx_valid, 0);
    checkValue("t6 cmd_ready in reset", cmd_ready, 0);
    checkValue("t6 tx_ready in reset", tx_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkValue("t6 cmd_ready after release", cmd_ready, 1);
    checkValue("t6 tx_ready after release", tx_ready, 1);
    checkValue("t6 rx empty after release", rx_valid, 0);
    checkValue("t6 rrq after release", hbus_rrq, 0);
    checkValue("t6 adr_o cleared", hbus_adr_o, 0);
    expq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
